// File: rtl/hs_dpath_pkt_pkg.sv
// Shared types and lane arithmetic for the stream packetizer.
// Lane masks are built at a fixed maximum width and narrowed by the user.
package hs_dpath_pkt_pkg;

   localparam int unsigned MAX_STROBE = 64;

   typedef enum logic {
      PKT_IDLE,
      PKT_STREAM
   } pkt_state_e;

   // Low `tail` lanes enabled; a zero tail means the beat is full.
   function automatic logic [MAX_STROBE-1:0] tail_strobe(input int unsigned tail,
                                                         input int unsigned width);
      logic [MAX_STROBE-1:0] mask;
      int unsigned           n;
      n    = (tail == 0) ? width : tail;
      mask = '0;
      for (int unsigned i = 0; i < MAX_STROBE; i++) begin
         mask[6'(i)] = (i < n);
      end
      return mask;
   endfunction

   // Beats needed for `len` lanes; the sum is carried wider than the length field.
   function automatic int unsigned beats_of(input int unsigned len,
                                            input int unsigned width);
      return (len + width - 1) >> $clog2(width);
   endfunction

endpackage

// File: rtl/hs_dpath_stream_packetizer.sv
// Transmit-side framer: one length command plus an unframed word stream in,
// a framed packet with out_last and a trailing-lane strobe out.
module hs_dpath_stream_packetizer
   import hs_dpath_pkt_pkg::*;
#(
   parameter type         DATA_TYPE    = logic [31:0],
   parameter int unsigned STROBE_UNIT  = 8,
   parameter int unsigned LEN_WIDTH    = 16,
   localparam int unsigned STROBE_WIDTH = $bits(DATA_TYPE) / STROBE_UNIT
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  DATA_TYPE                in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output DATA_TYPE                out_data,
   output logic                    out_valid,
   output logic                    out_last,
   input  logic                    out_ready,
   output logic [STROBE_WIDTH-1:0] out_strobe,
   output logic                    busy
);

   localparam int unsigned TAIL_W = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;

   if ((STROBE_WIDTH < 1) || ((STROBE_WIDTH & (STROBE_WIDTH - 1)) != 0) ||
       (STROBE_WIDTH > MAX_STROBE)) begin : g_bad_strobe
      $fatal(1, "hs_dpath_stream_packetizer: STROBE_WIDTH must be a power of two in 1..64");
   end

   pkt_state_e             state;
   logic [LEN_WIDTH-1:0]   remaining;
   logic [TAIL_W-1:0]      tail;

   logic                   cmd_hs;
   logic                   in_hs;
   logic                   out_hs;
   logic                   final_beat;
   logic [LEN_WIDTH-1:0]   cmd_beats;
   logic [TAIL_W-1:0]      cmd_tail;
   logic [STROBE_WIDTH-1:0] last_strobe;

   assign cmd_hs      = cmd_valid && cmd_ready && (state == PKT_IDLE);
   assign in_ready    = (state == PKT_STREAM) && (out_ready || !out_valid);
   assign in_hs       = in_valid && in_ready;
   assign out_hs      = out_valid && out_ready;
   assign final_beat  = (remaining == LEN_WIDTH'(1));
   assign cmd_beats   = LEN_WIDTH'(beats_of(32'(cmd_len), STROBE_WIDTH));
   assign cmd_tail    = TAIL_W'(cmd_len & LEN_WIDTH'(STROBE_WIDTH - 1));
   assign last_strobe = STROBE_WIDTH'(tail_strobe(32'(tail), STROBE_WIDTH));
   assign busy        = (state == PKT_STREAM) || out_valid;

   // Command/stream sequencing and the output register control fields.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= PKT_IDLE;
         cmd_ready  <= 1'b0;
         remaining  <= '0;
         tail       <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_strobe <= '0;
      end else begin
         case (state)
            PKT_IDLE: begin
               if (cmd_hs) begin
                  cmd_ready <= 1'b0;
                  remaining <= cmd_beats;
                  tail      <= cmd_tail;
                  // A zero-length command leaves a one-cycle gap on cmd_ready.
                  if (cmd_len != '0) begin
                     state <= PKT_STREAM;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            PKT_STREAM: begin
               if (in_hs) begin
                  remaining <= remaining - LEN_WIDTH'(1);
                  if (final_beat) begin
                     state     <= PKT_IDLE;
                     cmd_ready <= 1'b1;
                  end
               end
            end
            default: begin
               state <= PKT_IDLE;
            end
         endcase

         if (in_hs) begin
            out_valid  <= 1'b1;
            out_last   <= final_beat;
            out_strobe <= final_beat ? last_strobe : '1;
         end else if (out_hs) begin
            out_valid  <= 1'b0;
         end
      end
   end

   // Payload is qualified by out_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (in_hs) begin
         out_data <= in_data;
      end
   end

endmodule

// File: tb/tb_hs_dpath_stream_packetizer.sv
// Self-checking bench: a lane-counting model predicts each output beat when
// the input word is accepted; the monitor compares beats as they leave.
module tb_hs_dpath_stream_packetizer;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [15:0] cmd_len;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;
   logic [3:0]  out_strobe;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int beat_cnt = 0;
   int last_cnt = 0;
   int lanes_left = 0;
   int last_acc_cyc = 0;
   int prev_acc_cyc = 0;

   logic [36:0] sb_q[$];
   int          pend_q[$];

   hs_dpath_stream_packetizer dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .cmd_len    (cmd_len),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .out_strobe (out_strobe),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor and model, sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      logic [36:0] e;
      logic [3:0]  s;
      logic        l;
      cyc++;
      if (!aresetn) begin
         sb_q.delete();
         pend_q.delete();
         lanes_left = 0;
      end else begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("unexpected_beat", 64'(out_valid), 64'(0));
            end else begin
               e = sb_q[0];
               check_eq("out_data",   64'(out_data),   64'(e[36:5]));
               check_eq("out_last",   64'(out_last),   64'(e[4]));
               check_eq("out_strobe", 64'(out_strobe), 64'(e[3:0]));
               if (out_ready) begin
                  void'(sb_q.pop_front());
                  beat_cnt++;
                  if (out_last) last_cnt++;
               end
            end
         end
         if (cmd_valid && cmd_ready && (cmd_len != 16'd0)) pend_q.push_back(int'(cmd_len));
         if (in_valid && in_ready) begin
            if (lanes_left == 0) begin
               if (pend_q.size() == 0) check_eq("unexpected_accept", 64'(in_ready), 64'(0));
               else lanes_left = pend_q.pop_front();
            end
            if (lanes_left > 4) begin
               s = 4'hF;
               l = 1'b0;
               lanes_left -= 4;
            end else begin
               s = 4'((1 << lanes_left) - 1);
               l = (lanes_left != 0);
               lanes_left = 0;
            end
            sb_q.push_back({in_data, l, s});
            prev_acc_cyc = last_acc_cyc;
            last_acc_cyc = cyc;
         end
      end
   end

   task automatic send_cmd(input int len);
      bit done;
      done = 1'b0;
      cmd_len   = 16'(len);
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!done) check_eq("cmd_timeout", 64'(done), 64'(1));
   endtask

   task automatic send_words(input int len, input logic [31:0] base);
      bit done;
      int nb;
      nb = (len + 3) / 4;
      in_valid = 1'b1;
      for (int b = 0; b < nb; b++) begin
         in_data = base + 32'(b);
         done = 1'b0;
         for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
         end
         if (!done) check_eq("in_timeout", 64'(done), 64'(1));
      end
      in_valid = 1'b0;
   endtask

   task automatic send_packet(input int len, input logic [31:0] base);
      send_cmd(len);
      send_words(len, base);
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (sb_q.size() == 0 && !out_valid) break;
         @(posedge clk);
         #1;
      end
      check_eq("drain", 64'(sb_q.size()), 64'(0));
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         b0;
      int         l0;
      logic [3:0] pat;
      aresetn   = 1'b0;
      cmd_len   = '0;
      cmd_valid = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      pat       = 4'b1001;

      // Reset state
      #13;
      check_eq("rst_cmd_ready",  64'(cmd_ready),  64'(0));
      check_eq("rst_in_ready",   64'(in_ready),   64'(0));
      check_eq("rst_out_valid",  64'(out_valid),  64'(0));
      check_eq("rst_out_last",   64'(out_last),   64'(0));
      check_eq("rst_out_strobe", 64'(out_strobe), 64'(0));
      check_eq("rst_busy",       64'(busy),       64'(0));
      @(posedge clk);
      #3 aresetn = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

      // 1: ten lanes -> full, full, two-lane tail
      b0 = beat_cnt; l0 = last_cnt;
      send_packet(10, 32'hA000_0000);
      check_eq("t1_cmd_ready_after", 64'(cmd_ready), 64'(1));
      drain();
      check_eq("t1_beats", 64'(beat_cnt - b0), 64'(3));
      check_eq("t1_lasts", 64'(last_cnt - l0), 64'(1));

      // 2: back-to-back packets with a single input bubble
      b0 = beat_cnt; l0 = last_cnt;
      send_packet(8, 32'hB000_0000);
      send_packet(1, 32'hD000_0000);
      check_eq("t2_bubble", 64'(last_acc_cyc - prev_acc_cyc), 64'(2));
      drain();
      check_eq("t2_beats", 64'(beat_cnt - b0), 64'(3));
      check_eq("t2_lasts", 64'(last_cnt - l0), 64'(2));

      // 3: zero-length command
      b0 = beat_cnt;
      in_valid = 1'b1;
      in_data  = 32'hC0C0_C0C0;
      send_cmd(0);
      check_eq("t3_cmd_ready_low", 64'(cmd_ready), 64'(0));
      check_eq("t3_in_ready_a",    64'(in_ready),  64'(0));
      @(posedge clk);
      #1;
      check_eq("t3_cmd_ready_high", 64'(cmd_ready), 64'(1));
      check_eq("t3_in_ready_b",     64'(in_ready),  64'(0));
      check_eq("t3_busy",           64'(busy),      64'(0));
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("t3_beats", 64'(beat_cnt - b0), 64'(0));

      // 4: backpressure pattern 1,0,0,1 with continuous input
      b0 = beat_cnt; l0 = last_cnt;
      fork
         send_packet(16, 32'h4000_0000);
         begin
            for (int i = 0; i < 12; i++) begin
               @(posedge clk);
               #1 out_ready = pat[i % 4];
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check_eq("t4_beats", 64'(beat_cnt - b0), 64'(4));
      check_eq("t4_lasts", 64'(last_cnt - l0), 64'(1));

      // 5: reset in the middle of a packet
      b0 = beat_cnt;
      send_cmd(12);
      in_valid = 1'b1;
      in_data  = 32'h5555_0000;
      for (int i = 0; i < 50 && beat_cnt == b0; i++) begin
         @(posedge clk);
         #1;
      end
      check_eq("t5_first_beat", 64'(beat_cnt - b0), 64'(1));
      #1 aresetn = 1'b0;
      #1;
      check_eq("t5_out_valid", 64'(out_valid), 64'(0));
      check_eq("t5_busy",      64'(busy),      64'(0));
      check_eq("t5_in_ready",  64'(in_ready),  64'(0));
      check_eq("t5_cmd_ready", 64'(cmd_ready), 64'(0));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 aresetn = 1'b1;
      @(posedge clk);
      #1;
      check_eq("t5_cmd_ready_rel", 64'(cmd_ready), 64'(1));
      b0 = beat_cnt; l0 = last_cnt;
      send_packet(4, 32'hEEEE_0000);
      drain();
      check_eq("t5_beats", 64'(beat_cnt - b0), 64'(1));
      check_eq("t5_lasts", 64'(last_cnt - l0), 64'(1));

      // 6: maximum length
      b0 = beat_cnt; l0 = last_cnt;
      send_packet(65535, 32'h6000_0000);
      drain();
      check_eq("t6_beats", 64'(beat_cnt - b0), 64'(16384));
      check_eq("t6_lasts", 64'(last_cnt - l0), 64'(1));
      check_eq("t6_idle",  64'(busy),          64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
